if_id_stage: RTL and testbench

- Fetch-to-decode pipeline stage, directly downstream of the PC/fetch logic.
- Captures fetched instruction, PC and PC+4 into the decode-side register (InstrD, PCD, PCPlus4D).
- A DEPTH-entry skid FIFO holds instruction-memory responses that arrive while decode is stalled, so in-flight fetches are never lost.
- Honours StallD/FlushD from the hazard unit and reports back-pressure to fetch via fetch_ready.

---
 rtl/if_id_stage.sv | 141 ++++++++++++++
 tb/tb_if_id_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage : fetch-to-decode register with an in-order skid FIFO that
//               absorbs instruction-memory responses arriving during StallD.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module if_id_stage #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(32'h00000013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           PCF,
  input  logic [WIDTH-1:0]           PCPlus4F,
  input  logic [WIDTH-1:0]           InstrF,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic                       StallD,
  input  logic                       FlushD,
  output logic [WIDTH-1:0]           InstrD,
  output logic [WIDTH-1:0]           PCD,
  output logic [WIDTH-1:0]           PCPlus4D,
  output logic                       ValidD,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] pc4_mem   [DEPTH];

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] instr_q,  instr_d;
  logic [WIDTH-1:0] pc_q,     pc_d;
  logic [WIDTH-1:0] pc4_q,    pc4_d;
  logic             valid_q,  valid_d;

  logic             ready;
  logic             accept;
  logic             push;
  logic             pop;

  // Readiness comes from registered occupancy only, keeping fetch timing clean.
  assign ready  = (count_q < CW'(DEPTH));
  assign accept = fetch_valid & ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (FlushD) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      instr_d  = NOP;
      pc_d     = '0;
      pc4_d    = '0;
      valid_d  = 1'b0;
    end else if (!StallD) begin
      if (count_q != '0) begin
        // Buffered entries always drain ahead of a new bypass.
        instr_d = instr_mem[rd_ptr_q];
        pc_d    = pc_mem[rd_ptr_q];
        pc4_d   = pc4_mem[rd_ptr_q];
        valid_d = 1'b1;
        pop     = 1'b1;
        push    = accept;
      end else if (accept) begin
        instr_d = InstrF;
        pc_d    = PCF;
        pc4_d   = PCPlus4F;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP;
        pc_d    = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    end else begin
      push = accept;
    end

    if (!FlushD) begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= NOP;
      pc_q     <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is only read through valid pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= InstrF;
      pc_mem[wr_ptr_q]    <= PCF;
      pc4_mem[wr_ptr_q]   <= PCPlus4F;
    end
  end

  assign fetch_ready = ready;
  assign InstrD      = instr_q;
  assign PCD         = pc_q;
  assign PCPlus4D    = pc4_q;
  assign ValidD      = valid_q;
  assign fifo_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage : directed scenarios followed by random traffic, checked
//                  against a queue-based model of the fetch/decode stage.
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_id_stage;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [WIDTH-1:0]        PCF = '0;
  logic [WIDTH-1:0]        PCPlus4F = '0;
  logic [WIDTH-1:0]        InstrF = '0;
  logic                    fetch_valid = 1'b0;
  logic                    fetch_ready;
  logic                    StallD = 1'b0;
  logic                    FlushD = 1'b0;
  logic [WIDTH-1:0]        InstrD;
  logic [WIDTH-1:0]        PCD;
  logic [WIDTH-1:0]        PCPlus4D;
  logic                    ValidD;
  logic [$clog2(DEPTH):0]  fifo_count;

  if_id_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .StallD(StallD), .FlushD(FlushD), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  ent_t        mdec;
  bit          mvalid;
  logic [31:0] fpc;
  int          total  = 0;
  int          passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bubble_dec();
    mdec   = '{NOP, 32'h0, 32'h0};
    mvalid = 1'b0;
  endtask

  // One clock of stimulus; the model applies the stage rules then compares.
  task automatic step(input bit fv, input bit stall, input bit flush, input bit r);
    bit   acc;
    ent_t e;
    @(negedge clk);
    fetch_valid = fv;
    StallD      = stall;
    FlushD      = flush;
    rst         = r;
    PCF         = fpc;
    PCPlus4F    = fpc + 32'd4;
    InstrF      = fpc + 32'hA0;
    acc = fv && (mq.size() < DEPTH);
    e   = '{fpc + 32'hA0, fpc, fpc + 32'd4};
    @(posedge clk);
    #1;
    if (r || flush) begin
      mq.delete();
      bubble_dec();
    end else if (!stall) begin
      if (mq.size() > 0) begin
        mdec   = mq.pop_front();
        mvalid = 1'b1;
        if (acc) mq.push_back(e);
      end else if (acc) begin
        mdec   = e;
        mvalid = 1'b1;
      end else begin
        bubble_dec();
      end
    end else if (acc) begin
      mq.push_back(e);
    end
    check("InstrD",      InstrD,              mdec.instr);
    check("PCD",         PCD,                 mdec.pc);
    check("PCPlus4D",    PCPlus4D,            mdec.pc4);
    check("ValidD",      {31'b0, ValidD},     {31'b0, mvalid});
    check("fifo_count",  32'(fifo_count),     32'(mq.size()));
    check("fetch_ready", {31'b0, fetch_ready}, {31'b0, (mq.size() < DEPTH)});
    if (r || flush) fpc = {$urandom_range(0, 16'hFFFF), 2'b00};
    else if (acc)   fpc = fpc + 32'd4;
  endtask

  initial begin
    bubble_dec();
    fpc = 32'h0;

    // Reset then stream 0x0..0x10
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("reset_instr", InstrD, NOP);
    check("reset_ready", {31'b0, fetch_ready}, 32'd1);
    fpc = 32'h0;
    step(1, 0, 0, 0);
    check("stream_first_pc", PCD, 32'h0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("stream_instr", InstrD, 32'hA8);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("stream_pcd_10", PCD, 32'h10);

    // Stall buffering and in-order drain
    repeat (4) step(1, 1, 0, 0);
    check("stall_hold_pc", PCD, 32'h10);
    check("stall_count",   32'(fifo_count), 32'd2);
    step(1, 0, 0, 0);
    check("drain_first", PCD, 32'h14);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("drain_third", PCD, 32'h1C);

    // Flush with full FIFO
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    check("flush_instr", InstrD, NOP);
    check("flush_count", 32'(fifo_count), 32'd0);

    // Simultaneous push/pop
    fpc = 32'h20;
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    check("pushpop_pc", PCD, 32'h20);
    check("pushpop_cnt", 32'(fifo_count), 32'd1);
    step(0, 0, 0, 0);
    check("pushpop_next", PCD, 32'h24);

    // Bubble insertion then resume
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Mid-operation reset
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    fpc = 32'h40;
    step(1, 0, 0, 0);
    check("post_reset_pc", PCD, 32'h40);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
